// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory sequencer: memType codes, FSM states,
// and helpers that turn a memType into a transfer length or an alignment check.
package mem_pkg;

  localparam logic [1:0] MEM_WORD = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  // Code 2'b11 is treated as a word.
  function automatic logic [2:0] byte_count(input logic [1:0] mem_type);
    case (mem_type)
      MEM_BYTE: byte_count = 3'd1;
      MEM_HALF: byte_count = 3'd2;
      default:  byte_count = 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] mem_type,
                                         input logic [1:0] addr_lo);
    case (mem_type)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = addr_lo[0];
      default:  is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-result extension: byte/half are sign- or zero-extended
// to 32 bits, word passes through unchanged.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  memType_i,
  input  logic        memSign_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (memType_i)
      MEM_BYTE: ext_o = {{24{memSign_i & raw_i[7]}}, raw_i[7:0]};
      MEM_HALF: ext_o = {{16{memSign_i & raw_i[15]}}, raw_i[15:0]};
      default:  ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// Serialises one core load/store into little-endian byte transfers on a
// byte-wide single-port RAM, stalling the core until the access finishes.
module mem_access_seq
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  memWrite_en_i,
  input  logic [1:0]            memType_i,
  input  logic                  memSign_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [31:0]           rdata_o,
  output logic                  misaligned_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]            ram_wdata_o,
  output logic                  ram_we_o,
  output logic                  ram_re_o,
  input  logic [7:0]            ram_rdata_i
);

  seq_state_e            state_q, state_d;
  logic [1:0]            k_q, k_d;
  logic                  we_q, we_d;
  logic [1:0]            type_q, type_d;
  logic                  sign_q, sign_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           asm_q, asm_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mis_q, mis_d;

  logic [1:0]            last_k;
  logic [31:0]           asm_fin;
  logic [31:0]           ext;

  assign last_k = 2'(byte_count(type_q) - 3'd1);

  // Assembly register with the final byte (arriving during DRAIN) merged in.
  always_comb begin
    asm_fin = asm_q;
    asm_fin[{last_k, 3'b000} +: 8] = ram_rdata_i;
  end

  load_extend u_ext (
    .raw_i     (asm_fin),
    .memType_i (type_q),
    .memSign_i (sign_q),
    .ext_o     (ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      we_q    <= 1'b0;
      type_q  <= MEM_WORD;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      we_q    <= we_d;
      type_q  <= type_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    we_d    = we_q;
    type_d  = type_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d    = memWrite_en_i;
          type_d  = memType_i;
          sign_d  = memSign_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          k_d     = 2'd0;
          asm_d   = '0;
          if (is_misaligned(memType_i, addr_i[1:0])) begin
            mis_d   = 1'b1;
            rdata_d = '0;
            state_d = S_DONE;
          end else begin
            mis_d   = 1'b0;
            state_d = S_XFER;
          end
        end
      end
      S_XFER: begin
        // Read data lags the strobe by one cycle, so byte k-1 lands now.
        if (!we_q && (k_q != 2'd0))
          asm_d[{k_q - 2'd1, 3'b000} +: 8] = ram_rdata_i;
        k_d = k_q + 2'd1;
        if (k_q == last_k) begin
          if (we_q) begin
            rdata_d = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        asm_d   = asm_fin;
        rdata_d = ext;
        state_d = S_DONE;
      end
      S_DONE: begin
        // req_i still belongs to the finished instruction here.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_we_o    = 1'b0;
    ram_re_o    = 1'b0;
    if (state_q == S_XFER) begin
      ram_addr_o = addr_q + ADDR_WIDTH'(k_q);
      ram_we_o   = we_q;
      ram_re_o   = !we_q;
      if (we_q)
        ram_wdata_o = wdata_q[{k_q, 3'b000} +: 8];
    end
  end

  assign stall_o      = !rst && (((state_q != S_IDLE) && (state_q != S_DONE)) ||
                                 ((state_q == S_IDLE) && req_i));
  assign done_o       = (state_q == S_DONE);
  assign misaligned_o = done_o & mis_q;
  assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed + randomized bench for mem_access_seq with a byte RAM and a
// separate reference memory image that predicts load results and stored bytes.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        memWrite_en_i;
  logic [1:0]  memType_i;
  logic        memSign_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        misaligned_o;
  logic [31:0] ram_addr_o;
  logic [7:0]  ram_wdata_o;
  logic        ram_we_o;
  logic        ram_re_o;
  logic [7:0]  ram_rdata_i;

  logic [7:0] ram   [0:1023];
  logic [7:0] ref_m [0:1023];

  int tests = 0;
  int fails = 0;

  mem_access_seq #(.ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .memWrite_en_i (memWrite_en_i),
    .memType_i     (memType_i),
    .memSign_i     (memSign_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .stall_o       (stall_o),
    .done_o        (done_o),
    .rdata_o       (rdata_o),
    .misaligned_o  (misaligned_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wdata_o   (ram_wdata_o),
    .ram_we_o      (ram_we_o),
    .ram_re_o      (ram_re_o),
    .ram_rdata_i   (ram_rdata_i)
  );

  always #5 clk = ~clk;

  // Environment RAM: writes land on the edge, read data appears next cycle.
  always @(posedge clk) begin
    if (ram_we_o) ram[ram_addr_o[9:0]] <= ram_wdata_o;
    if (ram_re_o) ram_rdata_i <= ram[ram_addr_o[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access from request to DONE; hold keeps req_i high through DONE.
  task automatic run_op(input bit we, input logic [1:0] t, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold);
    int n, exp_done, cyc, nwe, nre;
    bit mis, got;
    longint v;
    logic [31:0] exp_r;
    n   = (t == 2'b01) ? 1 : (t == 2'b10) ? 2 : 4;
    mis = (t == 2'b01) ? 1'b0 : (t == 2'b10) ? a[0] : (a[1:0] != 2'b00);
    exp_r = 32'h0;
    if (!mis && we) begin
      for (int k = 0; k < n; k++) ref_m[10'(a + 32'(k))] = 8'(wd >> (8 * k));
    end else if (!mis) begin
      v = 0;
      for (int k = 0; k < n; k++) v += longint'(ref_m[10'(a + 32'(k))]) << (8 * k);
      if (sg && v >= (64'd1 << (8 * n - 1))) v -= (64'd1 << (8 * n));
      exp_r = v[31:0];
    end
    exp_done = mis ? 1 : (we ? n + 1 : n + 2);

    @(negedge clk);
    req_i = 1'b1; memWrite_en_i = we; memType_i = t; memSign_i = sg;
    addr_i = a; wdata_i = wd;
    #1 chk("stall_c0", 32'(stall_o), 32'd1);
    cyc = 0; got = 0; nwe = 0; nre = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (ram_we_o) begin
        chk("we_addr", ram_addr_o, a + 32'(nwe));
        chk("we_data", 32'(ram_wdata_o), 32'(8'(wd >> (8 * nwe))));
        nwe++;
      end
      if (ram_re_o) begin
        chk("re_addr", ram_addr_o, a + 32'(nre));
        nre++;
      end
      if (done_o) begin
        got = 1;
        chk("done_cyc", 32'(cyc), 32'(exp_done));
        chk("misalign", 32'(misaligned_o), 32'(mis));
        chk("rdata", rdata_o, exp_r);
        chk("stall_done", 32'(stall_o), 32'd0);
        chk("ram_idle_done", 32'({ram_we_o, ram_re_o}), 32'd0);
        if (!hold) req_i = 1'b0;
      end else begin
        chk("stall_busy", 32'(stall_o), 32'd1);
      end
    end
    if (!got) chk("timeout", 32'd0, 32'd1);
    chk("n_writes", 32'(nwe), (we && !mis) ? 32'(n) : 32'd0);
    chk("n_reads",  32'(nre), (!we && !mis) ? 32'(n) : 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_i = 1'b0; memWrite_en_i = 1'b0; memType_i = 2'b00;
    memSign_i = 1'b0; addr_i = '0; wdata_i = '0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]   = 8'($urandom);
      ref_m[i] = ram[i];
    end
    #2;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_ram", 32'({ram_we_o, ram_re_o, misaligned_o}), 32'd0);
    chk("rst_addr", ram_addr_o, 32'd0);
    @(negedge clk); rst = 1'b0;

    // sw DEADBEEF at 0x100, then check the RAM image
    run_op(1'b1, 2'b00, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0);
    for (int k = 0; k < 4; k++) chk("sw_ram", 32'(ram[10'h100 + 10'(k)]), 32'(ref_m[10'h100 + 10'(k)]));
    chk("sw_ram_ef", 32'(ram[10'h100]), 32'hEF);

    // byte loads of 0x80
    ram[10'h101] = 8'h80; ref_m[10'h101] = 8'h80;
    run_op(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 1'b0);
    chk("lb_val", rdata_o, 32'hFFFFFF80);
    run_op(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1'b0);
    chk("lbu_val", rdata_o, 32'h00000080);

    // half loads of 0x9234
    ram[10'h202] = 8'h34; ref_m[10'h202] = 8'h34;
    ram[10'h203] = 8'h92; ref_m[10'h203] = 8'h92;
    run_op(1'b0, 2'b10, 1'b1, 32'h202, 32'h0, 1'b0);
    chk("lh_val", rdata_o, 32'hFFFF9234);
    run_op(1'b0, 2'b10, 1'b0, 32'h202, 32'h0, 1'b0);
    chk("lhu_val", rdata_o, 32'h00009234);

    // misaligned lw and sh
    run_op(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 1'b0);
    run_op(1'b1, 2'b10, 1'b0, 32'h301, 32'h12345678, 1'b0);

    // reset in cycle 2 of sw 0x100: only the first byte reaches RAM
    for (int k = 1; k < 4; k++) begin
      ram[10'h100 + 10'(k)] = 8'h11; ref_m[10'h100 + 10'(k)] = 8'h11;
    end
    ram[10'h100] = 8'h00; ref_m[10'h100] = 8'hEF;
    @(negedge clk);
    req_i = 1'b1; memWrite_en_i = 1'b1; memType_i = 2'b00; memSign_i = 1'b0;
    addr_i = 32'h100; wdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("rstm_we_c1", 32'(ram_we_o), 32'd1);
    @(negedge clk);
    chk("rstm_we_c2", 32'(ram_we_o), 32'd1);
    rst = 1'b1; req_i = 1'b0;
    #1;
    chk("rstm_we", 32'(ram_we_o), 32'd0);
    chk("rstm_stall", 32'(stall_o), 32'd0);
    chk("rstm_addr", ram_addr_o, 32'd0);
    chk("rstm_done", 32'(done_o), 32'd0);
    @(negedge clk); rst = 1'b0;
    chk("rstm_b0", 32'(ram[10'h100]), 32'hEF);
    chk("rstm_b1", 32'(ram[10'h101]), 32'h11);
    run_op(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b0);
    chk("rstm_lw", rdata_o, 32'h111111EF);

    // held request: next request taken in DONE+1
    run_op(1'b1, 2'b10, 1'b0, 32'h040, 32'h0000A5C3, 1'b1);
    run_op(1'b0, 2'b10, 1'b1, 32'h040, 32'h0, 1'b0);
    chk("held_lh", rdata_o, 32'hFFFFA5C3);

    // randomized mix, including memType 2'b11 and misaligned addresses
    for (int i = 0; i < 60; i++) begin
      run_op(1'($urandom), 2'($urandom), 1'($urandom),
             32'($urandom_range(0, 1019)), $urandom, 1'($urandom_range(0, 3) == 0));
    end
    @(negedge clk); req_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 1024; i++)
      if (ram[i] !== ref_m[i]) chk("ram_image", 32'(ram[i]), 32'(ref_m[i]));
    chk("final_idle", 32'({stall_o, done_o}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
